// File: rtl/cria_pkts_header.sv
// cria_pkts_header
//
// Builds the 7-word header placed in front of every event packet. One 64-bit
// word is presented at a time, selected by header_word_number, and is purely
// combinational from the current field registers and the event counter.
// The header is a NetFPGA IO-queue module header followed by Ethernet, IPv4,
// UDP and a sequence field.
//
// Header fields are software registers on the UDP register ring. The ring is
// a single register stage for both local accesses and pass-through traffic.
//
// Ports
//   clk, reset           : clock, synchronous active-high reset
//   reg_*_in             : register-ring inputs (req, ack, rd_wr_L, addr, data, src)
//   reg_*_out            : registered register-ring outputs
//   header_word_number   : header word index 0..6 (7 reads as all-zero)
//   evt_pkt_sent         : one-cycle pulse per emitted event packet; bumps seq
//   header_data          : selected header word
//   header_ctrl          : ctrl byte for the selected word (0xFF on word 0)
//   enable               : CTRL register bit 0
module cria_pkts_header #(
  parameter int          DATA_WIDTH        = 64,
  parameter int          CTRL_WIDTH        = 8,
  parameter int          HEADER_LENGTH     = 7,
  parameter int          UDP_REG_SRC_WIDTH = 2,
  parameter logic [18:0] BLOCK_TAG         = 19'h00100
) (
  input  logic                         clk,
  input  logic                         reset,

  input  logic                         reg_req_in,
  input  logic                         reg_ack_in,
  input  logic                         reg_rd_wr_L_in,
  input  logic [22:0]                  reg_addr_in,
  input  logic [31:0]                  reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0] reg_src_in,

  output logic                         reg_req_out,
  output logic                         reg_ack_out,
  output logic                         reg_rd_wr_L_out,
  output logic [22:0]                  reg_addr_out,
  output logic [31:0]                  reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0] reg_src_out,

  input  logic [2:0]                   header_word_number,
  input  logic                         evt_pkt_sent,
  output logic [DATA_WIDTH-1:0]        header_data,
  output logic [CTRL_WIDTH-1:0]        header_ctrl,
  output logic                         enable
);

  // Register offsets within this block
  localparam logic [3:0] OFF_DST_MAC_HI = 4'd0;
  localparam logic [3:0] OFF_DST_MAC_LO = 4'd1;
  localparam logic [3:0] OFF_SRC_MAC_HI = 4'd2;
  localparam logic [3:0] OFF_SRC_MAC_LO = 4'd3;
  localparam logic [3:0] OFF_SRC_IP     = 4'd4;
  localparam logic [3:0] OFF_DST_IP     = 4'd5;
  localparam logic [3:0] OFF_UDP_PORTS  = 4'd6;
  localparam logic [3:0] OFF_OUT_PORT   = 4'd7;
  localparam logic [3:0] OFF_CTRL       = 4'd8;
  localparam logic [3:0] OFF_SEQ        = 4'd9;

  // Fixed header constants
  localparam logic [15:0] MOD_WORD_LEN   = 16'd14;
  localparam logic [15:0] MOD_BYTE_LEN   = 16'd112;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [7:0]  IP_TOS         = 8'h00;
  localparam logic [15:0] IP_TOTAL_LEN   = 16'd98;
  localparam logic [15:0] IP_FLAGS_FRAG  = 16'h4000;
  localparam logic [7:0]  IP_TTL         = 8'h40;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam logic [15:0] UDP_LEN        = 16'd78;
  localparam logic [15:0] PAYLOAD_WORDS  = 16'd8;

  // One's-complement IPv4 header checksum over the ten header half-words
  // with the checksum field itself taken as zero. Ten 16-bit words fit in
  // 20 bits; two end-around folds are always enough to absorb every carry.
  function automatic logic [15:0] ip_checksum(input logic [15:0] ip_id,
                                              input logic [31:0] sip,
                                              input logic [31:0] dip);
    logic [15:0] hw [10];
    logic [19:0] sum;
    logic [16:0] fold1;
    logic [16:0] fold2;
    hw[0] = {IP_VER_IHL, IP_TOS};
    hw[1] = IP_TOTAL_LEN;
    hw[2] = ip_id;
    hw[3] = IP_FLAGS_FRAG;
    hw[4] = {IP_TTL, IP_PROTO_UDP};
    hw[5] = 16'h0000;
    hw[6] = sip[31:16];
    hw[7] = sip[15:0];
    hw[8] = dip[31:16];
    hw[9] = dip[15:0];
    sum = 20'd0;
    for (int i = 0; i < 10; i++) begin
      sum = sum + {4'd0, hw[i]};
    end
    fold1 = {1'b0, sum[15:0]} + {13'd0, sum[19:16]};
    fold2 = {1'b0, fold1[15:0]} + {16'd0, fold1[16]};
    return ~fold2[15:0];
  endfunction

  // Software registers
  logic [15:0] dst_mac_hi_q, dst_mac_hi_d;
  logic [31:0] dst_mac_lo_q, dst_mac_lo_d;
  logic [15:0] src_mac_hi_q, src_mac_hi_d;
  logic [31:0] src_mac_lo_q, src_mac_lo_d;
  logic [31:0] src_ip_q,     src_ip_d;
  logic [31:0] dst_ip_q,     dst_ip_d;
  logic [31:0] udp_ports_q,  udp_ports_d;
  logic [7:0]  out_port_q,   out_port_d;
  logic        ctrl_q,       ctrl_d;
  logic [31:0] seq_q,        seq_d;

  // Ring output stage
  logic                         req_q,  req_d;
  logic                         ack_q,  ack_d;
  logic                         rdwr_q, rdwr_d;
  logic [22:0]                  addr_q, addr_d;
  logic [31:0]                  data_q, data_d;
  logic [UDP_REG_SRC_WIDTH-1:0] src_q,  src_d;

  logic [3:0]  offset;
  logic        local_hit;
  logic        wr_en;
  logic [31:0] rd_val;

  assign offset    = reg_addr_in[3:0];
  // Only an unacknowledged request carrying our tag is ours; everything else
  // (including requests another block already served) rides through.
  assign local_hit = reg_req_in && !reg_ack_in && (reg_addr_in[22:4] == BLOCK_TAG);
  assign wr_en     = local_hit && !reg_rd_wr_L_in;

  // Register read mux; narrow registers are zero-extended
  always_comb begin
    rd_val = 32'd0;
    case (offset)
      OFF_DST_MAC_HI: rd_val = {16'd0, dst_mac_hi_q};
      OFF_DST_MAC_LO: rd_val = dst_mac_lo_q;
      OFF_SRC_MAC_HI: rd_val = {16'd0, src_mac_hi_q};
      OFF_SRC_MAC_LO: rd_val = src_mac_lo_q;
      OFF_SRC_IP:     rd_val = src_ip_q;
      OFF_DST_IP:     rd_val = dst_ip_q;
      OFF_UDP_PORTS:  rd_val = udp_ports_q;
      OFF_OUT_PORT:   rd_val = {24'd0, out_port_q};
      OFF_CTRL:       rd_val = {31'd0, ctrl_q};
      OFF_SEQ:        rd_val = seq_q;
      default:        rd_val = 32'd0;
    endcase
  end

  // Register write decode; SEQ and offsets 10..15 have no write path
  always_comb begin
    dst_mac_hi_d = dst_mac_hi_q;
    dst_mac_lo_d = dst_mac_lo_q;
    src_mac_hi_d = src_mac_hi_q;
    src_mac_lo_d = src_mac_lo_q;
    src_ip_d     = src_ip_q;
    dst_ip_d     = dst_ip_q;
    udp_ports_d  = udp_ports_q;
    out_port_d   = out_port_q;
    ctrl_d       = ctrl_q;
    if (wr_en) begin
      case (offset)
        OFF_DST_MAC_HI: dst_mac_hi_d = reg_data_in[15:0];
        OFF_DST_MAC_LO: dst_mac_lo_d = reg_data_in;
        OFF_SRC_MAC_HI: src_mac_hi_d = reg_data_in[15:0];
        OFF_SRC_MAC_LO: src_mac_lo_d = reg_data_in;
        OFF_SRC_IP:     src_ip_d     = reg_data_in;
        OFF_DST_IP:     dst_ip_d     = reg_data_in;
        OFF_UDP_PORTS:  udp_ports_d  = reg_data_in;
        OFF_OUT_PORT:   out_port_d   = reg_data_in[7:0];
        OFF_CTRL:       ctrl_d       = reg_data_in[0];
        default: ;
      endcase
    end
  end

  // Event counter wraps naturally at 2^32
  always_comb begin
    seq_d = seq_q;
    if (evt_pkt_sent) begin
      seq_d = seq_q + 32'd1;
    end
  end

  // Ring next state: local reads substitute register data and local
  // accesses of either kind are acknowledged; all other fields pass through.
  always_comb begin
    req_d  = reg_req_in;
    ack_d  = reg_ack_in;
    rdwr_d = reg_rd_wr_L_in;
    addr_d = reg_addr_in;
    data_d = reg_data_in;
    src_d  = reg_src_in;
    if (local_hit) begin
      ack_d = 1'b1;
      if (reg_rd_wr_L_in) begin
        data_d = rd_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dst_mac_hi_q <= 16'hFFFF;
      dst_mac_lo_q <= 32'hFFFF_FFFF;
      src_mac_hi_q <= 16'h004E;
      src_mac_lo_q <= 32'h4632_4300;
      src_ip_q     <= 32'hC0A8_0001;
      dst_ip_q     <= 32'hC0A8_0002;
      udp_ports_q  <= 32'h1388_1389;
      out_port_q   <= 8'h01;
      ctrl_q       <= 1'b1;
      seq_q        <= 32'd0;
      req_q        <= 1'b0;
      ack_q        <= 1'b0;
      rdwr_q       <= 1'b0;
      addr_q       <= 23'd0;
      data_q       <= 32'd0;
      src_q        <= '0;
    end else begin
      dst_mac_hi_q <= dst_mac_hi_d;
      dst_mac_lo_q <= dst_mac_lo_d;
      src_mac_hi_q <= src_mac_hi_d;
      src_mac_lo_q <= src_mac_lo_d;
      src_ip_q     <= src_ip_d;
      dst_ip_q     <= dst_ip_d;
      udp_ports_q  <= udp_ports_d;
      out_port_q   <= out_port_d;
      ctrl_q       <= ctrl_d;
      seq_q        <= seq_d;
      req_q        <= req_d;
      ack_q        <= ack_d;
      rdwr_q       <= rdwr_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      src_q        <= src_d;
    end
  end

  assign reg_req_out     = req_q;
  assign reg_ack_out     = ack_q;
  assign reg_rd_wr_L_out = rdwr_q;
  assign reg_addr_out    = addr_q;
  assign reg_data_out    = data_q;
  assign reg_src_out     = src_q;
  assign enable          = ctrl_q;

  // Header word mux
  logic [47:0] dst_mac;
  logic [47:0] src_mac;
  logic [15:0] csum;
  logic [63:0] word;
  logic        word_valid;

  assign dst_mac    = {dst_mac_hi_q, dst_mac_lo_q};
  assign src_mac    = {src_mac_hi_q, src_mac_lo_q};
  assign csum       = ip_checksum(seq_q[15:0], src_ip_q, dst_ip_q);
  assign word_valid = (int'(header_word_number) < HEADER_LENGTH);

  always_comb begin
    word = 64'd0;
    case (header_word_number)
      3'd0: word = {8'h00, out_port_q, MOD_WORD_LEN, 16'd0, MOD_BYTE_LEN};
      3'd1: word = {dst_mac, src_mac[47:32]};
      3'd2: word = {src_mac[31:0], ETHERTYPE_IPV4, IP_VER_IHL, IP_TOS};
      3'd3: word = {IP_TOTAL_LEN, seq_q[15:0], IP_FLAGS_FRAG, IP_TTL, IP_PROTO_UDP};
      3'd4: word = {csum, src_ip_q, dst_ip_q[31:16]};
      3'd5: word = {dst_ip_q[15:0], udp_ports_q, UDP_LEN};
      3'd6: word = {16'h0000, seq_q, PAYLOAD_WORDS};
      default: word = 64'd0;
    endcase
  end

  assign header_data = word_valid ? word : 64'd0;
  // Word 0 carries the IO-queue module-header ctrl code
  assign header_ctrl = (header_word_number == 3'd0) ? {CTRL_WIDTH{1'b1}} : {CTRL_WIDTH{1'b0}};

endmodule

// File: tb/tb_cria_pkts_header.sv
module tb_cria_pkts_header;

  localparam logic [18:0] TAG = 19'h00100;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_req_in, reg_ack_in, reg_rd_wr_L_in;
  logic [22:0] reg_addr_in;
  logic [31:0] reg_data_in;
  logic [1:0]  reg_src_in;
  logic        reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [22:0] reg_addr_out;
  logic [31:0] reg_data_out;
  logic [1:0]  reg_src_out;
  logic [2:0]  header_word_number;
  logic        evt_pkt_sent;
  logic [63:0] header_data;
  logic [7:0]  header_ctrl;
  logic        enable;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] mreg [0:15];
  logic [31:0] mseq;

  cria_pkts_header #(
    .DATA_WIDTH(64), .CTRL_WIDTH(8), .HEADER_LENGTH(7),
    .UDP_REG_SRC_WIDTH(2), .BLOCK_TAG(TAG)
  ) dut (
    .clk(clk), .reset(reset),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
    .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
    .header_word_number(header_word_number), .evt_pkt_sent(evt_pkt_sent),
    .header_data(header_data), .header_ctrl(header_ctrl), .enable(enable)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (time %0t, required < 2000000)", $time);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < 16; i++) mreg[i] = 32'd0;
    mreg[0] = 32'h0000_FFFF;
    mreg[1] = 32'hFFFF_FFFF;
    mreg[2] = 32'h0000_004E;
    mreg[3] = 32'h4632_4300;
    mreg[4] = 32'hC0A8_0001;
    mreg[5] = 32'hC0A8_0002;
    mreg[6] = 32'h1388_1389;
    mreg[7] = 32'h0000_0001;
    mreg[8] = 32'h0000_0001;
    mseq    = 32'd0;
  endtask

  task automatic model_write(input int off, input logic [31:0] d);
    case (off)
      0, 2: mreg[off] = d & 32'h0000_FFFF;
      1, 3, 4, 5, 6: mreg[off] = d;
      7: mreg[off] = d & 32'h0000_00FF;
      8: mreg[off] = d & 32'h0000_0001;
      default: ;
    endcase
  endtask

  function automatic logic [31:0] model_read(input int off);
    if (off == 9) return mseq;
    if (off > 9) return 32'd0;
    return mreg[off];
  endfunction

  function automatic logic [15:0] model_csum();
    int unsigned s;
    logic [31:0] sip, dip;
    sip = mreg[4];
    dip = mreg[5];
    s = 32'h4500 + 98 + (mseq & 32'hFFFF) + 32'h4000 + 32'h4011
        + (sip >> 16) + (sip & 32'hFFFF) + (dip >> 16) + (dip & 32'hFFFF);
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    return 16'hFFFF - s[15:0];
  endfunction

  function automatic logic [63:0] model_word(input int n);
    logic [47:0] dm, sm;
    logic [31:0] sip, dip, ports;
    dm = {mreg[0][15:0], mreg[1]};
    sm = {mreg[2][15:0], mreg[3]};
    sip = mreg[4];
    dip = mreg[5];
    ports = mreg[6];
    case (n)
      0: return {8'h00, mreg[7][7:0], 16'd14, 16'd0, 16'd112};
      1: return {dm, sm[47:32]};
      2: return {sm[31:0], 16'h0800, 8'h45, 8'h00};
      3: return {16'd98, mseq[15:0], 16'h4000, 8'h40, 8'h11};
      4: return {model_csum(), sip, dip[31:16]};
      5: return {dip[15:0], ports, 16'd78};
      6: return {16'h0000, mseq, 16'd8};
      default: return 64'd0;
    endcase
  endfunction

  // ---------------- stimulus drivers ----------------
  task automatic idle_inputs();
    reg_req_in = 0; reg_ack_in = 0; reg_rd_wr_L_in = 0;
    reg_addr_in = 0; reg_data_in = 0; reg_src_in = 0;
    evt_pkt_sent = 0;
  endtask

  // Presents one ring transaction for a single cycle; returns at the next
  // falling edge with the registered outputs holding that transaction.
  task automatic ring_cycle(input logic req, input logic ack, input logic rdwr,
                            input logic [22:0] addr, input logic [31:0] data,
                            input logic [1:0] src, input logic evt);
    reg_req_in = req; reg_ack_in = ack; reg_rd_wr_L_in = rdwr;
    reg_addr_in = addr; reg_data_in = data; reg_src_in = src;
    evt_pkt_sent = evt;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic sweep_headers(input string tag);
    logic [7:0] exp_ctrl;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      header_word_number = n[2:0];
      #1;
      exp_ctrl = (n == 0) ? 8'hFF : 8'h00;
      checks++;
      if (header_data !== model_word(n)) begin
        errors++;
        $display("FAIL %s word%0d data: got %h expected %h", tag, n, header_data, model_word(n));
      end
      checks++;
      if (header_ctrl !== exp_ctrl) begin
        errors++;
        $display("FAIL %s word%0d ctrl: got %h expected %h", tag, n, header_ctrl, exp_ctrl);
      end
    end
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1;
    ring_cycle(1'b1, 1'b0, 1'b0, {TAG, 4'h7}, 32'h0000_0080, 2'b11, 1'b1);
    reset = 0;
    model_reset();
    checks++;
    if ({reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out} !== '0) begin
      errors++;
      $display("FAIL reset ring outputs: got req=%b ack=%b rw=%b addr=%h data=%h src=%h expected all 0",
               reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out);
    end
    checks++;
    if (enable !== 1'b1) begin
      errors++;
      $display("FAIL reset enable: got %b expected 1", enable);
    end
    sweep_headers("reset");
    checks++;
    if (model_word(4) !== {16'hB937, 32'hC0A8_0001, 16'hC0A8}) begin
      errors++;
      $display("FAIL reset checksum model: got %h expected B937", model_word(4));
    end
    ring_cycle(1'b1, 1'b0, 1'b1, {TAG, 4'h9}, 32'h0, 2'b00, 1'b0);
    checks++;
    if (reg_data_out !== 32'd0 || reg_ack_out !== 1'b1) begin
      errors++;
      $display("FAIL reset seq read: got data=%h ack=%b expected 0 ack 1", reg_data_out, reg_ack_out);
    end
  endtask

  task automatic test_out_port();
    ring_cycle(1'b1, 1'b0, 1'b0, {TAG, 4'h7}, 32'h0000_0004, 2'b01, 1'b0);
    model_write(7, 32'h4);
    checks++;
    if (reg_ack_out !== 1'b1 || reg_data_out !== 32'h4) begin
      errors++;
      $display("FAIL out_port write ack: got ack=%b data=%h expected ack 1 data 4", reg_ack_out, reg_data_out);
    end
    header_word_number = 3'd0;
    #1;
    checks++;
    if (header_data[63:48] !== 16'h0004) begin
      errors++;
      $display("FAIL out_port header: got %h expected 0004", header_data[63:48]);
    end
    @(negedge clk);
  endtask

  task automatic test_random_regs();
    int off;
    logic [31:0] d;
    logic [31:0] exp;
    for (int k = 0; k < 24; k++) begin
      off = $urandom_range(0, 15);
      d = $urandom;
      ring_cycle(1'b1, 1'b0, 1'b0, {TAG, off[3:0]}, d, 2'($urandom_range(0, 3)), 1'b0);
      model_write(off, d);
      checks++;
      if (reg_ack_out !== 1'b1 || reg_rd_wr_L_out !== 1'b0 || reg_data_out !== d
          || reg_addr_out !== {TAG, off[3:0]}) begin
        errors++;
        $display("FAIL regwr off%0d: got ack=%b rw=%b addr=%h data=%h expected ack 1 rw 0 addr %h data %h",
                 off, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, {TAG, off[3:0]}, d);
      end
      ring_cycle(1'b1, 1'b0, 1'b1, {TAG, off[3:0]}, $urandom, 2'b10, 1'b0);
      exp = model_read(off);
      checks++;
      if (reg_ack_out !== 1'b1 || reg_data_out !== exp) begin
        errors++;
        $display("FAIL regrd off%0d: got ack=%b data=%h expected ack 1 data %h", off, reg_ack_out, reg_data_out, exp);
      end
      checks++;
      if (enable !== mreg[8][0]) begin
        errors++;
        $display("FAIL enable after off%0d: got %b expected %b", off, enable, mreg[8][0]);
      end
    end
    sweep_headers("regs");
  endtask

  task automatic test_events();
    int bursts;
    int len;
    logic [31:0] pre;
    for (int b = 0; b < 3; b++) begin
      ring_cycle(1'b0, 1'b0, 1'b0, 23'd0, 32'd0, 2'b00, 1'b1);
      mseq = mseq + 1;
    end
    ring_cycle(1'b1, 1'b0, 1'b1, {TAG, 4'h9}, 32'h0, 2'b00, 1'b0);
    checks++;
    if (reg_data_out !== mseq) begin
      errors++;
      $display("FAIL seq after 3 pulses: got %h expected %h", reg_data_out, mseq);
    end
    sweep_headers("evt3");
    bursts = $urandom_range(3, 6);
    for (int b = 0; b < bursts; b++) begin
      len = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) begin
        ring_cycle(1'b0, 1'b0, 1'b0, 23'd0, 32'd0, 2'b00, 1'b1);
        mseq = mseq + 1;
      end
      @(negedge clk);
    end
    // write to SEQ is ignored, simultaneous pulse + read returns old value
    ring_cycle(1'b1, 1'b0, 1'b0, {TAG, 4'h9}, 32'hDEAD_BEEF, 2'b00, 1'b0);
    pre = mseq;
    ring_cycle(1'b1, 1'b0, 1'b1, {TAG, 4'h9}, 32'h0, 2'b00, 1'b1);
    mseq = mseq + 1;
    checks++;
    if (reg_data_out !== pre) begin
      errors++;
      $display("FAIL seq read with pulse: got %h expected %h", reg_data_out, pre);
    end
    sweep_headers("evtburst");
  endtask

  task automatic test_passthrough();
    int mode;
    logic [18:0] t;
    logic        req, ack, rw;
    logic [22:0] a;
    logic [31:0] d;
    logic [1:0]  s;
    for (int k = 0; k < 12; k++) begin
      mode = k % 3;
      t = 19'($urandom);
      if (t == TAG) t = t ^ 19'h1;
      rw = 1'($urandom);
      d = $urandom;
      s = 2'($urandom_range(0, 3));
      req = 1'b1;
      ack = 1'b0;
      a = {t, 4'($urandom_range(0, 8))};
      if (mode == 1) begin ack = 1'b1; a = {TAG, 4'($urandom_range(0, 8))}; end
      if (mode == 2) begin req = 1'b0; a = {TAG, 4'($urandom_range(0, 8))}; end
      ring_cycle(req, ack, rw, a, d, s, 1'b0);
      checks++;
      if (reg_req_out !== req || reg_ack_out !== ack || reg_rd_wr_L_out !== rw
          || reg_addr_out !== a || reg_data_out !== d || reg_src_out !== s) begin
        errors++;
        $display("FAIL passthru mode%0d: got %b %b %b %h %h %h expected %b %b %b %h %h %h", mode,
                 reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out,
                 req, ack, rw, a, d, s);
      end
    end
    sweep_headers("passthru");
  endtask

  task automatic test_ctrl_unused();
    ring_cycle(1'b1, 1'b0, 1'b0, {TAG, 4'h8}, 32'h0, 2'b00, 1'b0);
    model_write(8, 32'h0);
    checks++;
    if (enable !== 1'b0) begin
      errors++;
      $display("FAIL ctrl clear enable: got %b expected 0", enable);
    end
    ring_cycle(1'b1, 1'b0, 1'b0, {TAG, 4'hC}, 32'h1234_5678, 2'b00, 1'b0);
    ring_cycle(1'b1, 1'b0, 1'b1, {TAG, 4'hC}, 32'hAAAA_5555, 2'b01, 1'b0);
    checks++;
    if (reg_data_out !== 32'd0 || reg_ack_out !== 1'b1) begin
      errors++;
      $display("FAIL unused offset read: got data=%h ack=%b expected 0 ack 1", reg_data_out, reg_ack_out);
    end
    ring_cycle(1'b1, 1'b0, 1'b0, {TAG, 4'h8}, 32'hFFFF_FFFF, 2'b00, 1'b0);
    model_write(8, 32'hFFFF_FFFF);
    checks++;
    if (enable !== 1'b1) begin
      errors++;
      $display("FAIL ctrl set enable: got %b expected 1", enable);
    end
  endtask

  task automatic test_seq_wrap();
    force dut.seq_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.seq_q;
    mseq = 32'hFFFF_FFFF;
    ring_cycle(1'b1, 1'b0, 1'b1, {TAG, 4'h9}, 32'h0, 2'b00, 1'b0);
    checks++;
    if (reg_data_out !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL seq preload: got %h expected ffffffff", reg_data_out);
    end
    sweep_headers("preload");
    ring_cycle(1'b0, 1'b0, 1'b0, 23'd0, 32'd0, 2'b00, 1'b1);
    mseq = mseq + 1;
    ring_cycle(1'b1, 1'b0, 1'b1, {TAG, 4'h9}, 32'h0, 2'b00, 1'b0);
    checks++;
    if (reg_data_out !== 32'd0) begin
      errors++;
      $display("FAIL seq wrap: got %h expected 0", reg_data_out);
    end
    sweep_headers("wrap");
  endtask

  task automatic test_reset_during_access();
    ring_cycle(1'b1, 1'b0, 1'b0, {TAG, 4'h4}, 32'h0A0B_0C0D, 2'b00, 1'b0);
    model_write(4, 32'h0A0B_0C0D);
    reset = 1;
    ring_cycle(1'b1, 1'b0, 1'b1, {TAG, 4'h4}, 32'h0, 2'b11, 1'b1);
    reset = 0;
    model_reset();
    checks++;
    if ({reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out} !== '0) begin
      errors++;
      $display("FAIL reset mid-access outputs: got ack=%b data=%h addr=%h expected 0",
               reg_ack_out, reg_data_out, reg_addr_out);
    end
    sweep_headers("rst_access");
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    header_word_number = 3'd0;
    model_reset();
    repeat (3) @(negedge clk);
    test_reset();
    test_out_port();
    test_random_regs();
    test_events();
    test_passthrough();
    test_ctrl_unused();
    test_seq_wrap();
    test_reset_during_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
